// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: deframes MOSI into words, serialises readback onto MISO.
// All SPI pins are oversampled on clk; this is the only crossing into the CSR domain.
`timescale 1ns/1ps
module spi_slave_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_TX = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  frame_err,
  output logic                  tx_ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int S  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [S-1:0]  sclk_q, cs_q, mosi_q;
  logic          sclk_p_q, cs_p_q;
  logic [S:0]    fill_q;
  state_e        state_q;
  logic [CW-1:0] bit_cnt_q;
  logic          first_q;
  logic [W-1:0]  rx_shift_q, tx_shift_q, tx_buf_q;
  logic          tx_pend_q;
  logic          miso_q, miso_oe_q, rx_valid_q, frame_err_q, tx_ovf_q;
  logic [W-1:0]  rx_data_q;

  logic          sclk_s, cs_s, mosi_s;
  logic          sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic          start_d, load_word_d, consume_d;
  logic [W-1:0]  next_word_d, rx_word_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q   <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      sclk_p_q <= 1'b0;
      cs_p_q   <= 1'b1;
      fill_q   <= '0;
    end else begin
      sclk_q   <= {sclk_q[S-2:0], sclk};
      cs_q     <= {cs_q[S-2:0], cs_n};
      mosi_q   <= {mosi_q[S-2:0], mosi};
      sclk_p_q <= sclk_q[S-1];
      cs_p_q   <= cs_q[S-1];
      fill_q   <= {fill_q[S-1:0], 1'b1};
    end
  end

  always_comb begin
    sclk_s    = sclk_q[S-1];
    cs_s      = cs_q[S-1];
    mosi_s    = mosi_q[S-1];
    sclk_rise = sclk_s & ~sclk_p_q;
    sclk_fall = ~sclk_s & sclk_p_q;
    cs_fall   = ~cs_s & cs_p_q;
    cs_rise   = cs_s & ~cs_p_q;
    // Reset values in the chain must not look like a cs_n fall
    start_d   = (state_q == IDLE) & cs_fall & fill_q[S];
    load_word_d = start_d |
      ((state_q == ACTIVE) & ~cs_rise & ~sclk_rise & sclk_fall &
       (bit_cnt_q == '0) & ~first_q);
    consume_d   = load_word_d & tx_pend_q;
    next_word_d = tx_pend_q ? tx_buf_q : IDLE_TX;
    rx_word_d   = {rx_shift_q[W-2:0], mosi_s};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_pend_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (tx_load) begin
        tx_buf_q  <= tx_data;
        tx_pend_q <= 1'b1;
        if (tx_pend_q && !consume_d) tx_ovf_q <= 1'b1;
      end else if (consume_d) begin
        tx_pend_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          miso_oe_q <= 1'b0;
          miso_q    <= 1'b0;
          if (start_d) begin
            state_q    <= ACTIVE;
            bit_cnt_q  <= '0;
            first_q    <= 1'b1;
            tx_shift_q <= next_word_d;
            miso_q     <= next_word_d[W-1];
            miso_oe_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
            if (bit_cnt_q != '0) frame_err_q <= 1'b1;
          end else if (sclk_rise) begin
            first_q    <= 1'b0;
            rx_shift_q <= rx_word_d;
            if (bit_cnt_q == CW'(W - 1)) begin
              rx_data_q  <= rx_word_d;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt_q != '0) begin
              tx_shift_q <= {tx_shift_q[W-2:0], 1'b0};
              miso_q     <= tx_shift_q[W-2];
            end else if (!first_q) begin
              tx_shift_q <= next_word_d;
              miso_q     <= next_word_d[W-1];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign tx_ovf    = tx_ovf_q;

endmodule
